iob_bus_merge2: RTL and testbench

//  Merges the CPU's ibus and dbus IOb masters into one IOb memory port for a unified memory/interconnect.

---
 rtl/iob_bus_merge2_pkg.sv | 12 +
 rtl/iob_id_fifo.sv | 65 ++++++
 rtl/iob_bus_merge2.sv | 151 +++++++++++++++
 tb/tb_iob_bus_merge2.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_bus_merge2_pkg.sv
// Shared master IDs for iob_bus_merge2. The ID tags each outstanding read so that
// its response can be routed back to the master that issued it.
package iob_bus_merge2_pkg;

    localparam int unsigned ID_W = 1;

    typedef logic [ID_W-1:0] id_t;

    localparam id_t ID_IBUS = 1'b0;
    localparam id_t ID_DBUS = 1'b1;

endpackage

// File: rtl/iob_id_fifo.sv
// Register FIFO of master IDs for in-flight reads. Pointers wrap modulo DEPTH,
// so DEPTH must be a power of two.
module iob_id_fifo #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     cke_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // Requests are gated here so a push on full or a pop on empty is harmless.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (cke_i) begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (cke_i && do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/iob_bus_merge2.sv
// Merges the CPU ibus and dbus IOb masters onto one memory port: round-robin
// arbitration with a request lock, in-order read response routing via an ID FIFO.
module iob_bus_merge2
    import iob_bus_merge2_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,

    input  logic                ibus_avalid_i,
    input  logic [ADDR_W-1:0]   ibus_address_i,
    input  logic [DATA_W-1:0]   ibus_wdata_i,
    input  logic [DATA_W/8-1:0] ibus_wstrb_i,
    output logic [DATA_W-1:0]   ibus_rdata_o,
    output logic                ibus_rvalid_o,
    output logic                ibus_ready_o,

    input  logic                dbus_avalid_i,
    input  logic [ADDR_W-1:0]   dbus_address_i,
    input  logic [DATA_W-1:0]   dbus_wdata_i,
    input  logic [DATA_W/8-1:0] dbus_wstrb_i,
    output logic [DATA_W-1:0]   dbus_rdata_o,
    output logic                dbus_rvalid_o,
    output logic                dbus_ready_o,

    output logic                mem_avalid_o,
    output logic [ADDR_W-1:0]   mem_address_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_rvalid_i,
    input  logic                mem_ready_i,

    output logic                err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_level;
    id_t              fifo_head;

    logic ibus_rd;
    logic dbus_rd;
    logic ibus_req;
    logic dbus_req;
    logic gnt_rd;
    logic mem_valid;
    logic accept;
    logic rsp_valid;
    logic unused_fifo_level;

    id_t  gnt;
    id_t  gnt_q;
    id_t  last_q;
    logic lock_q;
    logic err_q;

    assign ibus_rd = (ibus_wstrb_i == '0);
    assign dbus_rd = (dbus_wstrb_i == '0);

    // A read that cannot get an ID slot is not a request at all, so a write from
    // the other master is never held behind it.
    assign ibus_req = ibus_avalid_i & ~(ibus_rd & fifo_full);
    assign dbus_req = dbus_avalid_i & ~(dbus_rd & fifo_full);

    always_comb begin
        gnt = gnt_q;
        if (!lock_q) begin
            case ({ibus_req, dbus_req})
                2'b10:   gnt = ID_IBUS;
                2'b01:   gnt = ID_DBUS;
                2'b11:   gnt = (last_q == ID_IBUS) ? ID_DBUS : ID_IBUS;
                default: gnt = gnt_q;
            endcase
        end
    end

    assign mem_valid = (gnt == ID_DBUS) ? dbus_req : ibus_req;
    assign gnt_rd    = (gnt == ID_DBUS) ? dbus_rd : ibus_rd;
    assign accept    = mem_valid & mem_ready_i;
    assign rsp_valid = mem_rvalid_i & ~fifo_empty;

    always_comb begin
        mem_avalid_o  = mem_valid;
        mem_address_o = '0;
        mem_wdata_o   = '0;
        mem_wstrb_o   = '0;
        if (mem_valid) begin
            if (gnt == ID_DBUS) begin
                mem_address_o = dbus_address_i;
                mem_wdata_o   = dbus_wdata_i;
                mem_wstrb_o   = dbus_wstrb_i;
            end else begin
                mem_address_o = ibus_address_i;
                mem_wdata_o   = ibus_wdata_i;
                mem_wstrb_o   = ibus_wstrb_i;
            end
        end
    end

    assign ibus_ready_o  = accept & (gnt == ID_IBUS);
    assign dbus_ready_o  = accept & (gnt == ID_DBUS);
    assign ibus_rvalid_o = rsp_valid & (fifo_head == ID_IBUS);
    assign dbus_rvalid_o = rsp_valid & (fifo_head == ID_DBUS);
    assign ibus_rdata_o  = mem_rdata_i;
    assign dbus_rdata_o  = mem_rdata_i;
    assign err_o         = err_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            gnt_q  <= ID_IBUS;
            last_q <= ID_IBUS;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (cke_i) begin
            gnt_q  <= gnt;
            lock_q <= mem_valid & ~mem_ready_i;
            if (accept) begin
                last_q <= gnt;
            end
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    iob_id_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .push_i   (accept & gnt_rd),
        .wdata_i  (gnt),
        .pop_i    (mem_rvalid_i),
        .rdata_o  (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

    assign unused_fifo_level = ^fifo_level;

endmodule

// File: tb/tb_iob_bus_merge2.sv
// Directed bench for iob_bus_merge2 with a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_iob_bus_merge2;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_OUTST = 4;

    logic        clk;
    logic        arst_n;
    logic        cke;
    logic        ibus_avalid, dbus_avalid;
    logic [31:0] ibus_address, dbus_address, ibus_wdata, dbus_wdata;
    logic [3:0]  ibus_wstrb, dbus_wstrb;
    logic [31:0] ibus_rdata, dbus_rdata;
    logic        ibus_rvalid, dbus_rvalid, ibus_ready, dbus_ready;
    logic        mem_avalid;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid, mem_ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    iob_bus_merge2 #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .cke_i          (cke),
        .ibus_avalid_i  (ibus_avalid),
        .ibus_address_i (ibus_address),
        .ibus_wdata_i   (ibus_wdata),
        .ibus_wstrb_i   (ibus_wstrb),
        .ibus_rdata_o   (ibus_rdata),
        .ibus_rvalid_o  (ibus_rvalid),
        .ibus_ready_o   (ibus_ready),
        .dbus_avalid_i  (dbus_avalid),
        .dbus_address_i (dbus_address),
        .dbus_wdata_i   (dbus_wdata),
        .dbus_wstrb_i   (dbus_wstrb),
        .dbus_rdata_o   (dbus_rdata),
        .dbus_rvalid_o  (dbus_rvalid),
        .dbus_ready_o   (dbus_ready),
        .mem_avalid_o   (mem_avalid),
        .mem_address_o  (mem_address),
        .mem_wdata_o    (mem_wdata),
        .mem_wstrb_o    (mem_wstrb),
        .mem_rdata_i    (mem_rdata),
        .mem_rvalid_i   (mem_rvalid),
        .mem_ready_i    (mem_ready),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who holds the port (-1 = nobody), last winner, IDs in flight.
    int  lock_m;
    int  last_m;
    int  q_m[$];
    bit  err_m;

    initial begin
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                lock_m = -1;
                last_m = 0;
                q_m.delete();
                err_m  = 1'b0;
            end else begin
                bit          full_m, el0, el1, av, acc, rv, win_rd;
                int          win;
                logic [31:0] e_addr, e_wdata;
                logic [3:0]  e_wstrb;
                full_m = (q_m.size() == MAX_OUTST);
                el0 = ibus_avalid && !((ibus_wstrb == 4'h0) && full_m);
                el1 = dbus_avalid && !((dbus_wstrb == 4'h0) && full_m);
                if (lock_m >= 0)      win = lock_m;
                else if (el0 && el1)  win = 1 - last_m;
                else if (el0)         win = 0;
                else if (el1)         win = 1;
                else                  win = -1;
                av = (win == 0) ? el0 : (win == 1) ? el1 : 1'b0;
                e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0; win_rd = 1'b0;
                if (av && win == 0) begin
                    e_addr = ibus_address; e_wdata = ibus_wdata; e_wstrb = ibus_wstrb;
                end else if (av) begin
                    e_addr = dbus_address; e_wdata = dbus_wdata; e_wstrb = dbus_wstrb;
                end
                win_rd = av && (e_wstrb == 4'h0);
                acc = av && mem_ready;
                rv  = mem_rvalid && (q_m.size() > 0);

                check("m_avalid", mem_avalid, av);
                check("m_address", mem_address, e_addr);
                check("m_wdata", mem_wdata, e_wdata);
                check("m_wstrb", mem_wstrb, e_wstrb);
                check("m_ibus_ready", ibus_ready, acc && win == 0);
                check("m_dbus_ready", dbus_ready, acc && win == 1);
                check("m_ibus_rvalid", ibus_rvalid, rv && q_m[0] == 0);
                check("m_dbus_rvalid", dbus_rvalid, rv && q_m[0] == 1);
                check("m_ibus_rdata", ibus_rdata, mem_rdata);
                check("m_dbus_rdata", dbus_rdata, mem_rdata);
                check("m_err", err, err_m);

                if (cke) begin
                    if (mem_rvalid && q_m.size() == 0) err_m = 1'b1;
                    if (rv) void'(q_m.pop_front());
                    if (acc && win_rd) q_m.push_back(win);
                    if (acc) last_m = win;
                    lock_m = (av && !mem_ready) ? win : -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ibus(input logic v, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        ibus_avalid = v; ibus_address = a; ibus_wstrb = s; ibus_wdata = d;
    endtask

    task automatic set_dbus(input logic v, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        dbus_avalid = v; dbus_address = a; dbus_wstrb = s; dbus_wdata = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avalid"}, mem_avalid, 1'b0);
        check({tag, "_address"}, mem_address, 32'h0);
        check({tag, "_readies"}, {ibus_ready, dbus_ready}, 2'b00);
        check({tag, "_rvalids"}, {ibus_rvalid, dbus_rvalid}, 2'b00);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0;
        cke    = 1'b1;
        set_ibus(0, 0, 0, 0);
        set_dbus(0, 0, 0, 0);
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        check_all_zero("reset");
        tick();
        arst_n = 1'b1;

        // Tie from reset: dbus wins first, ibus next cycle.
        tick();
        set_ibus(1, 32'h10, 4'h0, 32'h0);
        set_dbus(1, 32'h20, 4'hF, 32'hCAFE_0020);
        mem_ready = 1'b1;
        #2;
        check("tie_dbus_ready", dbus_ready, 1'b1);
        check("tie_ibus_wait", ibus_ready, 1'b0);
        check("tie_addr", mem_address, 32'h20);
        tick();
        set_dbus(0, 0, 0, 0);
        #2;
        check("tie_ibus_next", ibus_ready, 1'b1);
        check("tie_addr2", mem_address, 32'h10);
        tick();
        set_ibus(0, 0, 0, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_0010;
        #2;
        check("tie_rsp_ibus", {ibus_rvalid, dbus_rvalid}, 2'b10);
        tick();
        mem_rvalid = 1'b0;

        // Lone ibus read, response two cycles after accept.
        set_ibus(1, 32'h1000_0000, 4'h0, 32'h0);
        #2;
        check("rd_accept", ibus_ready, 1'b1);
        check("rd_addr", mem_address, 32'h1000_0000);
        tick();
        set_ibus(0, 0, 0, 0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #2;
        check("rd_rvalid", {ibus_rvalid, dbus_rvalid}, 2'b10);
        check("rd_data", ibus_rdata, 32'hDEAD_BEEF);
        tick();
        mem_rvalid = 1'b0;

        // dbus write makes dbus the last winner, so an unlocked tie would now pick ibus.
        set_dbus(1, 32'h24, 4'hF, 32'h2424_2424);
        tick();
        set_dbus(1, 32'h30, 4'h0, 32'h0);
        mem_ready = 1'b0;
        #2;
        check("lock_c1_addr", mem_address, 32'h30);
        tick();
        set_ibus(1, 32'h34, 4'h0, 32'h0);
        #2;
        check("lock_c2_addr", mem_address, 32'h30);
        check("lock_c2_ibus", ibus_ready, 1'b0);
        tick();
        #2;
        check("lock_c3_addr", mem_address, 32'h30);
        tick();
        mem_ready = 1'b1;
        #2;
        check("lock_release", {ibus_ready, dbus_ready}, 2'b01);
        tick();
        set_dbus(0, 0, 0, 0);
        #2;
        check("lock_ibus_after", ibus_ready, 1'b1);
        tick();
        set_ibus(0, 0, 0, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h3030;
        #2;
        check("lock_rsp1", {ibus_rvalid, dbus_rvalid}, 2'b01);
        tick();
        mem_rdata = 32'h3434;
        #2;
        check("lock_rsp2", {ibus_rvalid, dbus_rvalid}, 2'b10);
        tick();
        mem_rvalid = 1'b0;

        // Fill the ID FIFO with dbus reads, then a 5th read blocks while a write goes.
        for (int i = 0; i < 4; i++) begin
            set_dbus(1, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
            #2;
            check("fill_accept", dbus_ready, 1'b1);
            tick();
        end
        set_dbus(1, 32'h110, 4'h0, 32'h0);
        set_ibus(1, 32'h40, 4'hF, 32'h4040_4040);
        #2;
        check("full_wr_accept", {ibus_ready, dbus_ready}, 2'b10);
        check("full_wr_addr", mem_address, 32'h40);
        tick();
        set_ibus(0, 0, 0, 0);
        #2;
        check("full_rd_blocked", mem_avalid, 1'b0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h100;
        #2;
        check("full_no_bypass", mem_avalid, 1'b0);
        check("full_pop_dbus", dbus_rvalid, 1'b1);
        tick();
        mem_rvalid = 1'b0;
        #2;
        check("full_5th_accept", dbus_ready, 1'b1);
        check("full_5th_addr", mem_address, 32'h110);
        tick();
        set_dbus(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'(i);
            #2;
            check("drain_dbus", dbus_rvalid, 1'b1);
            tick();
        end
        mem_rvalid = 1'b0;

        // Interleaved reads with a response overlapping each push.
        set_ibus(1, 32'h200, 4'h0, 32'h0);
        tick();
        set_ibus(0, 0, 0, 0);
        set_dbus(1, 32'h300, 4'h0, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h200;
        #2;
        check("il_rsp_i0", {ibus_rvalid, dbus_rvalid}, 2'b10);
        tick();
        set_dbus(0, 0, 0, 0);
        set_ibus(1, 32'h204, 4'h0, 32'h0);
        mem_rdata = 32'h300;
        #2;
        check("il_rsp_d0", {ibus_rvalid, dbus_rvalid}, 2'b01);
        tick();
        set_ibus(0, 0, 0, 0);
        mem_rdata = 32'h204;
        #2;
        check("il_rsp_i1", {ibus_rvalid, dbus_rvalid}, 2'b10);
        tick();

        // FIFO now empty; with cke low the stray response must not set err.
        cke = 1'b0;
        mem_rdata = 32'hBAD0;
        #2;
        check("empty_no_rvalid", {ibus_rvalid, dbus_rvalid}, 2'b00);
        tick();
        cke = 1'b1;
        mem_rvalid = 1'b0;
        #2;
        check("cke_err_frozen", err, 1'b0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        #2;
        check("err_set", err, 1'b1);
        repeat (2) tick();
        check("err_sticky", err, 1'b1);

        arst_n = 1'b0;
        #2;
        check_all_zero("rst_pulse");
        tick();
        arst_n = 1'b1;
        tick();
        check("err_after_rst", err, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
